// File: rtl/vlsu_seq_if.sv
// Command, scratchpad and veggie-file signals of the vLSU command sequencer.
// master = sequencer side, slave = environment side.
interface vlsu_seq_if #(
    parameter int VEC_LEN = 32,
    parameter int ELEM_W  = 16,
    parameter int ADDR_W  = 20,
    parameter int VREG_W  = 5
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_is_store;
    logic                      cmd_spad_sel;
    logic [ADDR_W-1:0]         cmd_base;
    logic [ADDR_W-1:0]         cmd_stride;
    logic [VREG_W-1:0]         cmd_vreg;
    logic                      sp_req_valid;
    logic                      sp_req_ready;
    logic                      sp_req_sel;
    logic                      sp_req_we;
    logic [ADDR_W-1:0]         sp_req_addr;
    logic [ELEM_W-1:0]         sp_req_wdata;
    logic                      sp_rsp_valid;
    logic [ELEM_W-1:0]         sp_rsp_data;
    logic                      vg_rd_en;
    logic [VREG_W-1:0]         vg_rd_idx;
    logic [VEC_LEN*ELEM_W-1:0] vg_rd_data;
    logic                      vg_wr_en;
    logic [VREG_W-1:0]         vg_wr_idx;
    logic [VEC_LEN*ELEM_W-1:0] vg_wr_data;
    logic                      busy;
    logic                      done;

    modport master (
        input  cmd_valid, cmd_is_store, cmd_spad_sel, cmd_base, cmd_stride, cmd_vreg,
        input  sp_req_ready, sp_rsp_valid, sp_rsp_data, vg_rd_data,
        output cmd_ready, sp_req_valid, sp_req_sel, sp_req_we, sp_req_addr, sp_req_wdata,
        output vg_rd_en, vg_rd_idx, vg_wr_en, vg_wr_idx, vg_wr_data, busy, done
    );

    modport slave (
        output cmd_valid, cmd_is_store, cmd_spad_sel, cmd_base, cmd_stride, cmd_vreg,
        output sp_req_ready, sp_rsp_valid, sp_rsp_data, vg_rd_data,
        input  cmd_ready, sp_req_valid, sp_req_sel, sp_req_we, sp_req_addr, sp_req_wdata,
        input  vg_rd_en, vg_rd_idx, vg_wr_en, vg_wr_idx, vg_wr_data, busy, done
    );
endinterface

// File: rtl/vlsu_seq.sv
// vLSU command sequencer: splits one vector load/store into VEC_LEN strided
// scratchpad element requests, metering loads against the response FIFO depth.
module vlsu_seq #(
    parameter int VEC_LEN    = 32,
    parameter int ELEM_W     = 16,
    parameter int ADDR_W     = 20,
    parameter int VREG_W     = 5,
    parameter int FIFO_DEPTH = 13
) (
    input logic        CLK,
    input logic        nRST,
    vlsu_seq_if.master bus
);
    localparam int CW = $clog2(VEC_LEN + 1);
    localparam int IW = $clog2(VEC_LEN);
    localparam int OW = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LD_ISSUE = 3'd1;
    localparam logic [2:0] S_LD_DRAIN = 3'd2;
    localparam logic [2:0] S_LD_WB    = 3'd3;
    localparam logic [2:0] S_ST_RD    = 3'd4;
    localparam logic [2:0] S_ST_CAP   = 3'd5;
    localparam logic [2:0] S_ST_ISSUE = 3'd6;

    logic [2:0]                          state_q, state_d;
    logic                                sel_q, sel_d;
    logic [ADDR_W-1:0]                   stride_q, stride_d;
    logic [ADDR_W-1:0]                   addr_q, addr_d;
    logic [VREG_W-1:0]                   vreg_q, vreg_d;
    logic [CW-1:0]                       issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]                       rsp_cnt_q, rsp_cnt_d;
    logic [OW-1:0]                       out_cnt_q, out_cnt_d;
    logic [VEC_LEN-1:0][ELEM_W-1:0]      asm_q, asm_d;
    logic [VEC_LEN-1:0][ELEM_W-1:0]      sbuf_q, sbuf_d;

    logic req_valid, req_acc, rd_acc, rsp_take, last_st;

    assign req_valid = ((state_q == S_LD_ISSUE) && (out_cnt_q < OW'(FIFO_DEPTH)))
                     || (state_q == S_ST_ISSUE);
    assign req_acc   = req_valid && bus.sp_req_ready;
    assign rd_acc    = req_acc && (state_q == S_LD_ISSUE);
    // Responses only count while a load is in flight; strays elsewhere are dropped.
    assign rsp_take  = bus.sp_rsp_valid && ((state_q == S_LD_ISSUE) || (state_q == S_LD_DRAIN));
    assign last_st   = (state_q == S_ST_ISSUE) && req_acc && (issue_cnt_q == CW'(VEC_LEN - 1));

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        stride_d    = stride_q;
        addr_d      = addr_q;
        vreg_d      = vreg_q;
        issue_cnt_d = issue_cnt_q;
        rsp_cnt_d   = rsp_cnt_q;
        out_cnt_d   = out_cnt_q;
        asm_d       = asm_q;
        sbuf_d      = sbuf_q;

        if (req_acc) begin
            addr_d      = addr_q + stride_q;
            issue_cnt_d = issue_cnt_q + CW'(1);
        end
        case ({rd_acc, rsp_take})
            2'b10:   out_cnt_d = out_cnt_q + OW'(1);
            2'b01:   out_cnt_d = out_cnt_q - OW'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
        if (rsp_take) begin
            asm_d[rsp_cnt_q[IW-1:0]] = bus.sp_rsp_data;
            rsp_cnt_d                = rsp_cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: if (bus.cmd_valid) begin
                sel_d       = bus.cmd_spad_sel;
                stride_d    = bus.cmd_stride;
                addr_d      = bus.cmd_base;
                vreg_d      = bus.cmd_vreg;
                issue_cnt_d = '0;
                rsp_cnt_d   = '0;
                out_cnt_d   = '0;
                state_d     = bus.cmd_is_store ? S_ST_RD : S_LD_ISSUE;
            end
            S_LD_ISSUE: if (rd_acc && (issue_cnt_q == CW'(VEC_LEN - 1))) state_d = S_LD_DRAIN;
            S_LD_DRAIN: if (rsp_take && (rsp_cnt_q == CW'(VEC_LEN - 1))) state_d = S_LD_WB;
            S_LD_WB:    state_d = S_IDLE;
            S_ST_RD:    state_d = S_ST_CAP;
            S_ST_CAP: begin
                sbuf_d  = bus.vg_rd_data;
                state_d = S_ST_ISSUE;
            end
            S_ST_ISSUE: if (last_st) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            sel_q       <= 1'b0;
            stride_q    <= '0;
            addr_q      <= '0;
            vreg_q      <= '0;
            issue_cnt_q <= '0;
            rsp_cnt_q   <= '0;
            out_cnt_q   <= '0;
            asm_q       <= '0;
            sbuf_q      <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            stride_q    <= stride_d;
            addr_q      <= addr_d;
            vreg_q      <= vreg_d;
            issue_cnt_q <= issue_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
            out_cnt_q   <= out_cnt_d;
            asm_q       <= asm_d;
            sbuf_q      <= sbuf_d;
        end
    end

    assign bus.cmd_ready    = (state_q == S_IDLE);
    assign bus.sp_req_valid = req_valid;
    assign bus.sp_req_sel   = sel_q;
    assign bus.sp_req_we    = (state_q == S_ST_ISSUE);
    assign bus.sp_req_addr  = addr_q;
    assign bus.sp_req_wdata = (state_q == S_ST_ISSUE) ? sbuf_q[issue_cnt_q[IW-1:0]] : '0;
    assign bus.vg_rd_en     = (state_q == S_ST_RD);
    assign bus.vg_rd_idx    = vreg_q;
    assign bus.vg_wr_en     = (state_q == S_LD_WB);
    assign bus.vg_wr_idx    = vreg_q;
    assign bus.vg_wr_data   = asm_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_LD_WB) || last_st;
endmodule

// File: tb/tb_vlsu_seq.sv
// Scoreboard bench for vlsu_seq: scratchpad/veggie models, expected requests
// and write-back vectors queued at command time, popped as the DUT produces them.
module tb_vlsu_seq;
    localparam int VEC_LEN = 32, ELEM_W = 16, ADDR_W = 20, VREG_W = 5, FIFO_DEPTH = 13;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    vlsu_seq_if #(.VEC_LEN(VEC_LEN), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .VREG_W(VREG_W)) bus ();
    vlsu_seq #(.VEC_LEN(VEC_LEN), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .VREG_W(VREG_W),
               .FIFO_DEPTH(FIFO_DEPTH)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [ELEM_W-1:0] wdata;
        logic              sel;
    } req_t;
    typedef struct packed {
        logic [VREG_W-1:0]              idx;
        logic [VEC_LEN-1:0][ELEM_W-1:0] data;
    } vec_t;
    typedef struct {
        int                due;
        logic [ELEM_W-1:0] d;
    } rsp_t;

    req_t exp_req_q[$];
    vec_t exp_vec_q[$];
    rsp_t rsp_q[$];

    int n_cmp = 0, n_err = 0;
    int cyc = 0, lat_g = 1, rdy_pct = 100;
    int out_m = 0, acc_cnt = 0, done_cnt = 0, max_out = 0;
    int hs_cyc = 0, done_cyc = 0, last_acc_cyc = 0, wb_cyc = 0;
    bit cmd_active = 0, ld_phase = 0, prev_stall = 0, stray_en = 0, rd_seen = 0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [ELEM_W-1:0] prev_wdata = '0;
    logic [VREG_W-1:0] rd_idx = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [ELEM_W-1:0] sp_data(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ {a[19:16], 12'h3C5};
    endfunction

    function automatic logic [ELEM_W-1:0] vg_pat(input logic [VREG_W-1:0] v, input int i);
        logic [4:0] ii;
        ii = i[4:0];
        return {3'b000, v, 3'b110, ii};
    endfunction

    // Environment drive: ready, in-order read responses, veggie read data.
    initial begin
        bus.cmd_valid = 0; bus.cmd_is_store = 0; bus.cmd_spad_sel = 0;
        bus.cmd_base = '0; bus.cmd_stride = '0; bus.cmd_vreg = '0;
        bus.sp_req_ready = 0; bus.sp_rsp_valid = 0; bus.sp_rsp_data = '0;
        bus.vg_rd_data = '0;
        forever begin
            @(posedge CLK);
            cyc++;
            #1;
            bus.sp_req_ready = ($urandom_range(99) < rdy_pct);
            if (!stray_en) begin
                if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                    bus.sp_rsp_valid = 1;
                    bus.sp_rsp_data  = rsp_q[0].d;
                    void'(rsp_q.pop_front());
                end else begin
                    bus.sp_rsp_valid = 0;
                    bus.sp_rsp_data  = ELEM_W'($urandom);
                end
            end
            for (int i = 0; i < VEC_LEN; i++)
                bus.vg_rd_data[i*ELEM_W +: ELEM_W] = rd_seen ? vg_pat(rd_idx, i) : ELEM_W'($urandom);
        end
    end

    task automatic mon();
        req_t e;
        vec_t v;
        rd_seen = bus.vg_rd_en;
        rd_idx  = bus.vg_rd_idx;
        chk("cmd_ready", 64'(bus.cmd_ready), 64'(!cmd_active));
        chk("busy", 64'(bus.busy), 64'(cmd_active));
        if (ld_phase) chk("ld_valid", 64'(bus.sp_req_valid), 64'(out_m < FIFO_DEPTH));
        if (bus.sp_req_valid && prev_stall) begin
            chk("hold_addr", 64'(bus.sp_req_addr), 64'(prev_addr));
            chk("hold_wdata", 64'(bus.sp_req_wdata), 64'(prev_wdata));
        end
        if (bus.sp_req_valid && bus.sp_req_ready) begin
            if (exp_req_q.size() == 0) chk("req_extra", 64'(1), 64'(0));
            else begin
                e = exp_req_q.pop_front();
                chk("req_addr", 64'(bus.sp_req_addr), 64'(e.addr));
                chk("req_we", 64'(bus.sp_req_we), 64'(e.we));
                chk("req_sel", 64'(bus.sp_req_sel), 64'(e.sel));
                if (e.we) chk("req_wdata", 64'(bus.sp_req_wdata), 64'(e.wdata));
            end
            if (!bus.sp_req_we) begin
                rsp_q.push_back('{cyc + lat_g, sp_data(bus.sp_req_addr)});
                out_m++;
                acc_cnt++;
                last_acc_cyc = cyc;
            end
        end
        if (bus.sp_rsp_valid && !stray_en) out_m--;
        if (out_m > max_out) max_out = out_m;
        prev_stall = bus.sp_req_valid && !bus.sp_req_ready;
        prev_addr  = bus.sp_req_addr;
        prev_wdata = bus.sp_req_wdata;
        if (ld_phase && acc_cnt == VEC_LEN) ld_phase = 0;
        if (bus.vg_wr_en) begin
            wb_cyc = cyc;
            if (exp_vec_q.size() == 0) chk("wb_extra", 64'(1), 64'(0));
            else begin
                v = exp_vec_q.pop_front();
                chk("wb_idx", 64'(bus.vg_wr_idx), 64'(v.idx));
                for (int i = 0; i < VEC_LEN; i++)
                    chk($sformatf("wb_e%0d", i), 64'(bus.vg_wr_data[i*ELEM_W +: ELEM_W]), 64'(v.data[i]));
            end
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc   = cyc;
            cmd_active = 0;
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
            cmd_active = 1;
            hs_cyc     = cyc;
            if (!bus.cmd_is_store) begin
                ld_phase = 1;
                acc_cnt  = 0;
                out_m    = 0;
            end
        end
    endtask

    initial forever begin
        @(negedge CLK);
        if (nRST) mon();
    end

    task automatic chk_reset(input string pfx);
        chk({pfx, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
        chk({pfx, "_req_valid"}, 64'(bus.sp_req_valid), 64'(0));
        chk({pfx, "_req_we"}, 64'(bus.sp_req_we), 64'(0));
        chk({pfx, "_req_addr"}, 64'(bus.sp_req_addr), 64'(0));
        chk({pfx, "_req_sel"}, 64'(bus.sp_req_sel), 64'(0));
        chk({pfx, "_rd_en"}, 64'(bus.vg_rd_en), 64'(0));
        chk({pfx, "_wr_en"}, 64'(bus.vg_wr_en), 64'(0));
        chk({pfx, "_wr_idx"}, 64'(bus.vg_wr_idx), 64'(0));
        chk({pfx, "_wr_data0"}, 64'(bus.vg_wr_data == '0), 64'(1));
        chk({pfx, "_busy"}, 64'(bus.busy), 64'(0));
        chk({pfx, "_done"}, 64'(bus.done), 64'(0));
    endtask

    task automatic run_cmd(input bit st, input bit sel, input logic [ADDR_W-1:0] base,
                           input logic [ADDR_W-1:0] stride, input logic [VREG_W-1:0] vreg,
                           input int lat, input int pct, input bit abort);
        req_t r;
        vec_t v;
        logic [ADDR_W-1:0] a;
        int d0, t;
        lat_g = lat;
        rdy_pct = pct;
        a = base;
        for (int i = 0; i < VEC_LEN; i++) begin
            r.addr = a; r.we = st; r.sel = sel;
            r.wdata = st ? vg_pat(vreg, i) : '0;
            exp_req_q.push_back(r);
            v.data[i] = sp_data(a);
            a = a + stride;
        end
        v.idx = vreg;
        if (!st) exp_vec_q.push_back(v);
        d0 = done_cnt;
        @(posedge CLK); #1;
        bus.cmd_valid = 1; bus.cmd_is_store = st; bus.cmd_spad_sel = sel;
        bus.cmd_base = base; bus.cmd_stride = stride; bus.cmd_vreg = vreg;
        t = 0;
        while (!cmd_active && t < 50) begin @(posedge CLK); #1; t++; end
        bus.cmd_valid = 0;
        chk("cmd_accept", 64'(cmd_active || done_cnt != d0), 64'(1));
        if (abort) begin
            t = 0;
            while (acc_cnt < VEC_LEN && t < 500) begin @(posedge CLK); t++; end
            chk("abort_issued", 64'(acc_cnt), 64'(VEC_LEN));
            repeat (3) @(negedge CLK);
            #2 nRST = 0;
            #1 chk_reset("mid_rst");
            exp_req_q.delete(); exp_vec_q.delete(); rsp_q.delete();
            out_m = 0; ld_phase = 0; cmd_active = 0; prev_stall = 0;
            @(posedge CLK); #3 nRST = 1;
            return;
        end
        t = 0;
        while (done_cnt == d0 && t < 3000) begin @(posedge CLK); t++; end
        repeat (3) @(posedge CLK);
        chk("done_once", 64'(done_cnt - d0), 64'(1));
        chk("req_q_empty", 64'(exp_req_q.size()), 64'(0));
        chk("vec_q_empty", 64'(exp_vec_q.size()), 64'(0));
    endtask

    initial begin
        #1 chk_reset("rst");
        #20 nRST = 1;
        repeat (2) @(posedge CLK);

        run_cmd(0, 0, 20'h00100, 20'd1, 5'd7, 1, 100, 0);
        chk("ld_issue_span", 64'(last_acc_cyc - hs_cyc), 64'(VEC_LEN));
        chk("ld_wb_lat", 64'(wb_cyc - last_acc_cyc), 64'(2));

        max_out = 0;
        run_cmd(0, 0, 20'h02000, 20'd3, 5'd12, 20, 100, 0);
        chk("max_out", 64'(max_out), 64'(FIFO_DEPTH));

        run_cmd(1, 1, 20'hFFFF0, 20'd8, 5'd9, 1, 100, 0);
        chk("st_done_lat", 64'(done_cyc - hs_cyc), 64'(VEC_LEN + 2));

        run_cmd(1, 0, 20'h00345, 20'd5, 5'd3, 1, 50, 0);

        run_cmd(0, 1, 20'h04000, 20'd4, 5'd21, 20, 100, 1);

        @(posedge CLK); #2;
        stray_en = 1; bus.sp_rsp_valid = 1; bus.sp_rsp_data = 16'hDEAD;
        @(posedge CLK); #2;
        bus.sp_rsp_valid = 0; stray_en = 0;
        run_cmd(0, 1, 20'h00500, 20'd2, 5'd31, 1, 100, 0);

        run_cmd(0, 0, 20'hFFFE0, 20'd7, 5'd5, 5, 60, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
